// File: rtl/tb_result_checker.sv
// rtl/tb_result_checker.sv - scoreboard checker: counts matches/mismatches, captures first mismatch, flags timeout/abort
// Optional per-bit compare mask enabled by macro TB_RESULT_CHECKER_MASK_EN.
module tb_result_checker #(
  parameter int unsigned DATA_WIDTH  = 3,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MAX_ERR     = 0,
  parameter int unsigned TIMEOUT_CNT = 100
) (
  input  logic                  clk,
  input  logic                  testbench_reset,
  input  logic                  start,
  input  logic                  cmp_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_done,
`ifdef TB_RESULT_CHECKER_MASK_EN
  input  logic [DATA_WIDTH-1:0] cmp_mask,
`endif
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [CNT_WIDTH-1:0]  transaction_count,
  output logic [CNT_WIDTH-1:0]  first_mm_index,
  output logic [DATA_WIDTH-1:0] first_mm_dut,
  output logic [DATA_WIDTH-1:0] first_mm_exp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  max_err_reached
);

  // Cycle counter is sized to reach TIMEOUT_CNT independently of CNT_WIDTH.
  localparam int unsigned CYC_W = (TIMEOUT_CNT < 1) ? 1 : $clog2(TIMEOUT_CNT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;
  logic [CYC_W-1:0] cyc_count;
  logic [CYC_W-1:0] cyc_next;
  logic [CNT_WIDTH-1:0] mm_next;
  logic [DATA_WIDTH-1:0] mask;
  logic sample, is_match, enter_run, err_next, to_next;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

`ifdef TB_RESULT_CHECKER_MASK_EN
  assign mask = cmp_mask;
`else
  assign mask = '1;
`endif

  always_comb begin
    state_next = state;
    sample     = (state == RUN) && cmp_valid;
    is_match   = ((dut_data ^ exp_data) & mask) == '0;
    enter_run  = start && (state != RUN);
    mm_next    = (sample && !is_match) ? sat_inc(mismatch_count) : mismatch_count;
    cyc_next   = (&cyc_count) ? cyc_count : cyc_count + CYC_W'(1);
    err_next   = max_err_reached || (32'(mm_next) > MAX_ERR);
    to_next    = timeout || (32'(cyc_next) >= TIMEOUT_CNT);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (exp_done || err_next || to_next) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge testbench_reset) begin
    if (!testbench_reset) state <= IDLE;
    else                  state <= state_next;
  end

  always_ff @(posedge clk or negedge testbench_reset) begin
    if (!testbench_reset || enter_run) begin
      match_count       <= '0;
      mismatch_count    <= '0;
      transaction_count <= '0;
      first_mm_index    <= '0;
      first_mm_dut      <= '0;
      first_mm_exp      <= '0;
      cyc_count         <= '0;
      timeout           <= 1'b0;
      max_err_reached   <= 1'b0;
    end else if (state == RUN) begin
      cyc_count       <= cyc_next;
      timeout         <= to_next;
      max_err_reached <= err_next;
      if (sample) begin
        transaction_count <= sat_inc(transaction_count);
        if (is_match) begin
          match_count <= sat_inc(match_count);
        end else begin
          mismatch_count <= mm_next;
          // A saturated mismatch count never returns to zero, so zero means "no mismatch yet".
          if (mismatch_count == '0) begin
            first_mm_index <= transaction_count;
            first_mm_dut   <= dut_data;
            first_mm_exp   <= exp_data;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && !timeout && !max_err_reached
                && (32'(mismatch_count) <= MAX_ERR) && (transaction_count != '0);

endmodule

// File: tb/tb_tb_result_checker.sv
// tb/tb_tb_result_checker.sv - table-driven and directed-sequence bench for tb_result_checker
module tb_tb_result_checker;

  logic clk = 1'b0;
  logic testbench_reset = 1'b0;
  logic start = 1'b0, cmp_valid = 1'b0, exp_done = 1'b0;
  logic [2:0] dut_data = '0, exp_data = '0;
  logic [15:0] match_count, mismatch_count, transaction_count, first_mm_index;
  logic [2:0] first_mm_dut, first_mm_exp;
  logic busy, done, pass, timeout, max_err_reached;

  logic s_start = 1'b0, s_valid = 1'b0, s_done = 1'b0;
  logic [2:0] s_dut = '0, s_exp = '0;
  logic [3:0] s_match, s_mm, s_trans, s_idx;
  logic [2:0] s_fdut, s_fexp;
  logic s_busy, s_doneo, s_pass, s_to, s_err;

`ifdef TB_RESULT_CHECKER_MASK_EN
  logic [2:0] cmp_mask = 3'b111;
  logic [2:0] s_mask = 3'b111;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tb_result_checker u_dut (
    .clk(clk), .testbench_reset(testbench_reset), .start(start), .cmp_valid(cmp_valid),
    .dut_data(dut_data), .exp_data(exp_data), .exp_done(exp_done),
`ifdef TB_RESULT_CHECKER_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .match_count(match_count), .mismatch_count(mismatch_count),
    .transaction_count(transaction_count), .first_mm_index(first_mm_index),
    .first_mm_dut(first_mm_dut), .first_mm_exp(first_mm_exp), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .max_err_reached(max_err_reached)
  );

  tb_result_checker #(.CNT_WIDTH(4), .MAX_ERR(20)) u_sat (
    .clk(clk), .testbench_reset(testbench_reset), .start(s_start), .cmp_valid(s_valid),
    .dut_data(s_dut), .exp_data(s_exp), .exp_done(s_done),
`ifdef TB_RESULT_CHECKER_MASK_EN
    .cmp_mask(s_mask),
`endif
    .match_count(s_match), .mismatch_count(s_mm), .transaction_count(s_trans),
    .first_mm_index(s_idx), .first_mm_dut(s_fdut), .first_mm_exp(s_fexp), .busy(s_busy),
    .done(s_doneo), .pass(s_pass), .timeout(s_to), .max_err_reached(s_err)
  );

  typedef struct {
    logic st; logic v; logic [2:0] d; logic [2:0] e; logic ed;
    int m; int mm; int tr; logic bz; logic dn; logic ps; logic er;
    int idx; logic [2:0] fd; logic [2:0] fe;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input logic [2:0] d, input logic [2:0] e,
                       input logic ed);
    start = st; cmp_valid = v; dut_data = d; exp_data = e; exp_done = ed;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_match"}, 32'(match_count), 0);
    chk({tag, "_mm"}, 32'(mismatch_count), 0);
    chk({tag, "_trans"}, 32'(transaction_count), 0);
    chk({tag, "_idx"}, 32'(first_mm_index), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_to"}, 32'(timeout), 0);
    chk({tag, "_err"}, 32'(max_err_reached), 0);
  endtask

  initial begin
    int n;
    //         st  v  d     e     ed  m  mm tr bz dn ps er idx fd    fe
    tbl[0]  = '{1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[1]  = '{0, 1, 3'd5, 3'd5, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[2]  = '{0, 1, 3'd5, 3'd5, 0, 2, 0, 2, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[3]  = '{0, 1, 3'd5, 3'd5, 0, 3, 0, 3, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[4]  = '{0, 1, 3'd5, 3'd5, 0, 4, 0, 4, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[5]  = '{0, 1, 3'd5, 3'd5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[6]  = '{0, 0, 3'd0, 3'd0, 1, 5, 0, 5, 0, 1, 1, 0, 0, 3'd0, 3'd0};
    tbl[7]  = '{0, 1, 3'd0, 3'd1, 0, 5, 0, 5, 0, 1, 1, 0, 0, 3'd0, 3'd0};
    tbl[8]  = '{1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[9]  = '{0, 1, 3'd1, 3'd1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[10] = '{1, 1, 3'd7, 3'd7, 0, 2, 0, 2, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[11] = '{0, 1, 3'd6, 3'd2, 0, 2, 1, 3, 0, 1, 0, 1, 2, 3'd6, 3'd2};
    tbl[12] = '{1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[13] = '{0, 1, 3'd3, 3'd3, 1, 1, 0, 1, 0, 1, 1, 0, 0, 3'd0, 3'd0};

    #1;
    chk_all_zero("reset");
    repeat (2) tick();
    testbench_reset = 1'b1;
    tick();
    chk_all_zero("idle");

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].ed);
      tick();
      chk($sformatf("v%0d_match", i), 32'(match_count), 32'(tbl[i].m));
      chk($sformatf("v%0d_mm", i), 32'(mismatch_count), 32'(tbl[i].mm));
      chk($sformatf("v%0d_trans", i), 32'(transaction_count), 32'(tbl[i].tr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].ps));
      chk($sformatf("v%0d_err", i), 32'(max_err_reached), 32'(tbl[i].er));
      chk($sformatf("v%0d_idx", i), 32'(first_mm_index), 32'(tbl[i].idx));
      chk($sformatf("v%0d_fdut", i), 32'(first_mm_dut), 32'(tbl[i].fd));
      chk($sformatf("v%0d_fexp", i), 32'(first_mm_exp), 32'(tbl[i].fe));
    end
    drive(0, 0, 0, 0, 0);

    // Timeout with exp_done never asserted
    drive(1, 0, 0, 0, 0);
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 100);
    chk("to_flag", 32'(timeout), 1);
    chk("to_err", 32'(max_err_reached), 0);
    chk("to_pass", 32'(pass), 0);

    // Mismatch landing on the timeout cycle sets both flags
    drive(1, 0, 0, 0, 0);
    tick();
    start = 1'b0;
    repeat (99) tick();
    chk("both_busy99", 32'(busy), 1);
    drive(0, 1, 3'd4, 3'd1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("both_to", 32'(timeout), 1);
    chk("both_err", 32'(max_err_reached), 1);
    chk("both_done", 32'(done), 1);
    chk("both_pass", 32'(pass), 0);
    chk("both_idx", 32'(first_mm_index), 0);

    // Reset in cycle 3 of RUN, then a clean run
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 3'd2, 3'd2, 0);
    tick();
    tick();
    chk("mid_match", 32'(match_count), 2);
    testbench_reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    drive(0, 0, 0, 0, 0);
    #2 testbench_reset = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("clean_busy", 32'(busy), 1);
    chk("clean_trans0", 32'(transaction_count), 0);
    drive(0, 1, 3'd6, 3'd6, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("clean_match", 32'(match_count), 1);
    chk("clean_trans", 32'(transaction_count), 1);
    chk("clean_pass", 32'(pass), 1);

    // Saturation with 4-bit counters
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1; s_dut = 3'd3; s_exp = 3'd3;
    repeat (20) tick();
    s_valid = 1'b0;
    chk("sat_match", 32'(s_match), 15);
    chk("sat_trans", 32'(s_trans), 15);
    chk("sat_mm", 32'(s_mm), 0);
    chk("sat_busy", 32'(s_busy), 1);
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    chk("sat_done", 32'(s_doneo), 1);
    chk("sat_pass", 32'(s_pass), 1);

`ifdef TB_RESULT_CHECKER_MASK_EN
    cmp_mask = 3'b011;
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 3'b100, 3'b000, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("mask_match", 32'(match_count), 1);
    chk("mask_mm", 32'(mismatch_count), 0);
    chk("mask_pass", 32'(pass), 1);
    cmp_mask = 3'b111;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_result_checker.md
TB_RESULT_CHECKER -- requirements
Module: tb_result_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, width of compared vectors.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of all counters.
REQ-003 SHALL have parameter MAX_ERR, default 0, mismatches tolerated before abort.
REQ-004 SHALL have parameter TIMEOUT_CNT, default 100, max RUN-state cycles.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port testbench_reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  single-cycle run request.
REQ-008 SHALL have port cmp_valid  input  1  dut_data/exp_data valid this cycle.
REQ-009 SHALL have port dut_data  input  DATA_WIDTH  DUT output sample.
REQ-010 SHALL have port exp_data  input  DATA_WIDTH  expected-vector sample.
REQ-011 SHALL have port exp_done  input  1  expected-vector source exhausted.
REQ-012 SHALL have ports match_count, mismatch_count, transaction_count  output  CNT_WIDTH each  result counters.
REQ-013 SHALL have ports first_mm_index  output  CNT_WIDTH, first_mm_dut and first_mm_exp  output  DATA_WIDTH  first-mismatch capture.
REQ-014 SHALL have ports busy, done, pass, timeout, max_err_reached  output  1 each  status.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE->RUN on start; DONE->RUN on start; start in RUN ignored.
REQ-017 Entering RUN SHALL clear all counters, capture regs, cycle counter, status flags in the same edge.
REQ-018 In RUN, each cycle with cmp_valid SHALL increment transaction_count and exactly one of match_count (dut_data==exp_data) or mismatch_count, visible the next cycle.
REQ-019 cmp_valid outside RUN SHALL be ignored.
REQ-020 All counters SHALL saturate at all-ones, no wrap.
REQ-021 On the first mismatch of a run, first_mm_index SHALL load transaction_count value before increment, first_mm_dut/first_mm_exp the sampled data; later mismatches do not overwrite.
REQ-022 max_err_reached SHALL set when the updated mismatch_count > MAX_ERR, sticky until next RUN entry.
REQ-023 RUN cycle counter SHALL increment each RUN cycle; timeout SHALL set when it reaches TIMEOUT_CNT.
REQ-024 RUN->DONE on exp_done, max_err_reached, or timeout, whichever first; comparison sampled in the same cycle as exp_done SHALL still be counted.
REQ-025 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-026 pass SHALL be 1 in DONE iff timeout=0, max_err_reached=0, mismatch_count<=MAX_ERR, transaction_count>0; pass=0 outside DONE.
REQ-027 Simultaneous timeout and max_err_reached SHALL both be flagged; pass=0.

Reset
REQ-028 testbench_reset low SHALL asynchronously force IDLE, all counters and capture regs to 0, all status outputs to 0.
REQ-029 Reset asserted mid-RUN SHALL abandon the run; after release the block waits in IDLE for start.

Configuration
REQ-030 Macro TB_RESULT_CHECKER_MASK_EN defined: SHALL add input cmp_mask DATA_WIDTH; only bits with cmp_mask=1 participate in match/mismatch decision; capture regs store unmasked data.
REQ-031 Macro undefined: cmp_mask port SHALL be absent and all DATA_WIDTH bits compared.

Verification
REQ-032 Reset, start, 5 cmp_valid cycles all equal (3'b101), then exp_done -> match=5, mismatch=0, transaction=5, done=1, pass=1.
REQ-033 MAX_ERR=0, start, matches at indices 0-1, mismatch at index 2 (dut 3'b110, exp 3'b010) -> first_mm_index=2, first_mm_dut=3'b110, first_mm_exp=3'b010, max_err_reached=1, DONE next cycle, pass=0.
REQ-034 TIMEOUT_CNT=100, start, never assert exp_done -> timeout=1 and DONE after 100 RUN cycles, pass=0.
REQ-035 CNT_WIDTH=4, MAX_ERR=20, 20 matching samples -> match_count holds 15, no wrap.
REQ-036 Reset asserted on cycle 3 of RUN -> all outputs 0 immediately, IDLE; new start then runs clean with counters from 0.
REQ-037 With TB_RESULT_CHECKER_MASK_EN, cmp_mask=3'b011, dut 3'b100, exp 3'b000 -> counted as match.
